// File: rtl/uart_div_ctrl_if.sv
// Byte-level link between the divider controller and the UART receiver/transmitter,
// plus the controller's status flags.
interface uart_div_ctrl_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       div0;
  logic       overrun;

  modport master (
    input  rx_ready, rx_data, tx_done,
    output tx_start, tx_data, busy, div0, overrun
  );

  modport slave (
    output rx_ready, rx_data, tx_done,
    input  tx_start, tx_data, busy, div0, overrun
  );
endinterface

// File: rtl/uart_div_ctrl.sv
// Collects a dividend and a divisor from the UART byte stream (MSB first), runs a
// restoring divide and returns quotient then remainder bytes to the transmitter.
module uart_div_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic            clk,
  input  logic            rst,
  uart_div_ctrl_if.master bus
);
  localparam int NB    = WIDTH / 8;
  localparam int CNT_W = $clog2(2 * NB + 1);
  localparam int IT_W  = $clog2(WIDTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {RX_A, RX_B, DIV, TX_SEND, TX_WAIT} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IT_W-1:0]    iter_reg, iter_next;
  logic [TO_W-1:0]    tmo_reg, tmo_next;
  logic [WIDTH-1:0]   ra_reg, ra_next;
  logic [WIDTH-1:0]   rb_reg, rb_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [2*WIDTH-1:0] txbuf_reg, txbuf_next;
  logic               div0_reg, div0_next;
  logic               overrun_reg, overrun_next;
  logic               busy, tx_start;

  // rem_shift is the WIDTH+1-bit working remainder; its MSB never survives a
  // step, so only WIDTH bits need to be held between cycles.
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   q_step;
  logic [WIDTH-1:0]   ra_shift, rb_shift;
  logic               in_frame;

  assign rem_shift = {rem_reg, ra_reg[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, rb_reg};
  assign rem_step  = rem_ge ? WIDTH'(rem_shift - {1'b0, rb_reg}) : rem_shift[WIDTH-1:0];
  assign q_step    = {ra_reg[WIDTH-2:0], rem_ge};
  assign ra_shift  = (ra_reg << 8) | WIDTH'(bus.rx_data);
  assign rb_shift  = (rb_reg << 8) | WIDTH'(bus.rx_data);
  assign in_frame  = (state_reg == RX_B) || (state_reg == RX_A && cnt_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RX_A;
      cnt_reg     <= '0;
      iter_reg    <= '0;
      tmo_reg     <= '0;
      ra_reg      <= '0;
      rb_reg      <= '0;
      rem_reg     <= '0;
      txbuf_reg   <= '0;
      div0_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      iter_reg    <= iter_next;
      tmo_reg     <= tmo_next;
      ra_reg      <= ra_next;
      rb_reg      <= rb_next;
      rem_reg     <= rem_next;
      txbuf_reg   <= txbuf_next;
      div0_reg    <= div0_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    iter_next    = iter_reg;
    tmo_next     = tmo_reg;
    ra_next      = ra_reg;
    rb_next      = rb_reg;
    rem_next     = rem_reg;
    txbuf_next   = txbuf_reg;
    div0_next    = div0_reg;
    busy         = (state_reg == DIV) || (state_reg == TX_SEND) || (state_reg == TX_WAIT);
    tx_start     = 1'b0;
    // Bytes arriving while busy are dropped; only the sticky flag records them.
    overrun_next = overrun_reg | (bus.rx_ready & busy);

    case (state_reg)
      RX_A, RX_B: begin
        if (bus.rx_ready) begin
          tmo_next = '0;
          cnt_next = (cnt_reg == CNT_W'(NB - 1)) ? '0 : cnt_reg + CNT_W'(1);
          if (state_reg == RX_A) begin
            ra_next = ra_shift;
            if (cnt_reg == '0) div0_next = 1'b0;
            if (cnt_reg == CNT_W'(NB - 1)) state_next = RX_B;
          end else begin
            rb_next = rb_shift;
            if (cnt_reg == CNT_W'(NB - 1)) begin
              state_next = DIV;
              iter_next  = '0;
              rem_next   = '0;
              div0_next  = (rb_shift == '0);
            end
          end
        end else if (in_frame) begin
          if (tmo_reg == TO_W'(TIMEOUT)) begin
            state_next = RX_A;
            cnt_next   = '0;
            tmo_next   = '0;
          end else begin
            tmo_next = tmo_reg + TO_W'(1);
          end
        end
      end
      // A zero divisor always subtracts, so the quotient fills with ones and the
      // dividend shifts straight into the remainder: no special-case datapath.
      DIV: begin
        rem_next  = rem_step;
        ra_next   = q_step;
        iter_next = iter_reg + IT_W'(1);
        if (iter_reg == IT_W'(WIDTH - 1)) begin
          state_next = TX_SEND;
          cnt_next   = '0;
          txbuf_next = {q_step, rem_step};
        end
      end
      TX_SEND: begin
        tx_start   = 1'b1;
        state_next = TX_WAIT;
      end
      TX_WAIT: begin
        if (bus.tx_done) begin
          txbuf_next = txbuf_reg << 8;
          if (cnt_reg == CNT_W'(2 * NB - 1)) begin
            state_next = RX_A;
            cnt_next   = '0;
          end else begin
            state_next = TX_SEND;
            cnt_next   = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = RX_A;
    endcase
  end

  assign bus.tx_start = tx_start;
  assign bus.tx_data  = txbuf_reg[2*WIDTH-1 -: 8];
  assign bus.busy     = busy;
  assign bus.div0     = div0_reg;
  assign bus.overrun  = overrun_reg;
endmodule

// File: tb/tb_uart_div_ctrl.sv
// Directed bench for uart_div_ctrl: a 16-bit and a 32-bit instance driven through a
// shared stimulus path, checked every cycle against an arithmetic model.
module tb_uart_div_ctrl;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic tx_done = 1'b0;
  logic sel = 1'b0;
  int W = 16;
  int NB = 2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_div_ctrl_if if16 ();
  uart_div_ctrl_if if32 ();

  uart_div_ctrl #(.WIDTH(16), .TIMEOUT(TMO)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  uart_div_ctrl #(.WIDTH(32), .TIMEOUT(TMO)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  assign if16.rx_ready = rx_ready & ~sel;
  assign if16.rx_data  = rx_data;
  assign if16.tx_done  = tx_done & ~sel;
  assign if32.rx_ready = rx_ready & sel;
  assign if32.rx_data  = rx_data;
  assign if32.tx_done  = tx_done & sel;

  logic tx_start, busy, div0, overrun;
  logic [7:0] tx_data;
  assign tx_start = sel ? if32.tx_start : if16.tx_start;
  assign tx_data  = sel ? if32.tx_data  : if16.tx_data;
  assign busy     = sel ? if32.busy     : if16.busy;
  assign div0     = sel ? if32.div0     : if16.div0;
  assign overrun  = sel ? if32.overrun  : if16.overrun;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state, written only by the stimulus process.
  logic [7:0]  exp_tx[$];
  logic        m_busy = 1'b0;
  logic        m_div0 = 1'b0;
  logic        m_overrun = 1'b0;
  int          frame_cnt = 0;
  logic [63:0] a_acc, b_acc;
  int          t_last = 0;
  int          t_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_result(input int w, input logic [63:0] a,
                                               input logic [63:0] b);
    logic [63:0] mask, q, r;
    mask = (64'd1 << w) - 64'd1;
    if (b == 64'd0) begin
      q = mask;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return ((q & mask) << w) | (r & mask);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t_rx;
    logic [63:0] res;
    rx_ready = 1'b1;
    rx_data  = b;
    t_rx     = cyc;
    tick();
    rx_ready = 1'b0;
    $display("rx byte %02h at cycle %0d", b, t_rx);
    if (m_busy) begin
      m_overrun = 1'b1;
    end else begin
      if (frame_cnt == 0) begin
        m_div0 = 1'b0;
        a_acc  = 64'd0;
        b_acc  = 64'd0;
      end
      if (frame_cnt < NB) a_acc = (a_acc << 8) | 64'(b);
      else                b_acc = (b_acc << 8) | 64'(b);
      frame_cnt++;
      if (frame_cnt == 2 * NB) begin
        frame_cnt = 0;
        m_busy    = 1'b1;
        m_div0    = (b_acc == 64'd0);
        t_last    = t_rx;
        res       = model_result(W, a_acc, b_acc);
        for (int i = 0; i < 2 * NB; i++)
          exp_tx.push_back(8'(res >> (8 * (2 * NB - 1 - i))));
      end
    end
  endtask

  task automatic send_frame(input logic [63:0] ops);
    for (int i = 0; i < 2 * NB; i++)
      send_byte(8'(ops >> (8 * (2 * NB - 1 - i))));
  endtask

  task automatic wait_tx_start();
    int n = 0;
    while (!tx_start && n < W + 8) begin
      tick();
      n++;
    end
    if (!tx_start) begin
      checks++;
      errors++;
      $display("FAIL tx_start wait: got none within %0d cycles, required a pulse", n);
    end
  endtask

  task automatic serve_tx(input int delay, input bit inject, input bit last_rx);
    for (int i = 0; i < 2 * NB; i++) begin
      wait_tx_start();
      tick();
      for (int d = 0; d < delay; d++) begin
        if (inject && i == 1 && d == 0) send_byte(8'h55);
        else tick();
      end
      tx_done = 1'b1;
      t_done  = cyc;
      if (last_rx && i == 2 * NB - 1) send_byte(8'h55);
      else tick();
      tx_done = 1'b0;
    end
    m_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_ready = 1'b0;
    tx_done = 1'b0;
    exp_tx.delete();
    m_busy = 1'b0;
    m_div0 = 1'b0;
    m_overrun = 1'b0;
    frame_cnt = 0;
    tick();
    check("rst tx_start", 64'(tx_start), 64'd0);
    check("rst tx_data", 64'(tx_data), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst div0", 64'(div0), 64'd0);
    check("rst overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
  endtask

  // Compare process: status flags every cycle, each transmitted byte, its timing and hold.
  int rd_idx = 0;
  logic hold_valid = 1'b0;
  logic [7:0] held = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      rd_idx = 0;
      hold_valid = 1'b0;
    end else begin
      check("busy", 64'(busy), 64'(m_busy));
      check("div0", 64'(div0), 64'(m_div0));
      check("overrun", 64'(overrun), 64'(m_overrun));
      if (tx_start) begin
        if (rd_idx >= exp_tx.size()) begin
          check("unexpected tx_start", 64'(tx_start), 64'd0);
        end else begin
          if (rd_idx % (2 * NB) == 0)
            check("first tx_start latency", 64'(cyc - t_last), 64'(W + 1));
          else
            check("tx turnaround", 64'(cyc - t_done), 64'd1);
          check("tx_data", 64'(tx_data), 64'(exp_tx[rd_idx]));
          $display("tx byte %02h expected %02h at cycle %0d", tx_data, exp_tx[rd_idx], cyc);
          held = exp_tx[rd_idx];
          hold_valid = 1'b1;
          rd_idx++;
        end
      end else if (hold_valid) begin
        check("tx_data hold", 64'(tx_data), 64'(held));
        if (tx_done) hold_valid = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-computed results that pin the model.
    check("model 1000/7", model_result(16, 64'd1000, 64'd7), 64'h008E_0006);
    check("model 1234/0", model_result(16, 64'h1234, 64'd0), 64'hFFFF_1234);
    check("model 100/10", model_result(16, 64'd100, 64'd10), 64'h000A_0000);
    check("model ABCD/FF", model_result(16, 64'hABCD, 64'hFF), 64'h00AC_0079);
    check("model w32", model_result(32, 64'hFFFF_FFFF, 64'h10), 64'h0FFF_FFFF_0000_000F);

    do_reset();
    repeat (3) tick();

    send_frame(64'h03E8_0007);               // 1000 / 7
    serve_tx(2, 1'b0, 1'b0);
    repeat (3) tick();

    send_frame(64'h1234_0000);               // divide by zero
    serve_tx(1, 1'b0, 1'b0);
    repeat (3) tick();

    send_byte(8'h03);                        // stray byte, then inter-byte timeout
    repeat (TMO + 1) tick();
    frame_cnt = 0;
    send_frame(64'h0064_000A);
    serve_tx(0, 1'b0, 1'b0);

    send_frame(64'hABCD_00FF);
    serve_tx(0, 1'b0, 1'b0);
    send_frame(64'h0005_0100);               // divisor larger than dividend
    serve_tx(3, 1'b0, 1'b0);
    repeat (2) tick();

    send_frame(64'h03E8_0007);               // overrun during DIV, TX_WAIT, last tx_done
    repeat (3) tick();
    send_byte(8'h55);
    serve_tx(2, 1'b1, 1'b1);
    repeat (2) tick();
    send_frame(64'h00FF_0010);
    serve_tx(1, 1'b0, 1'b0);

    send_frame(64'h1234_0005);               // reset mid-DIV
    repeat (5) tick();
    do_reset();
    repeat (30) tick();
    send_frame(64'h1234_0005);               // reset mid-TX
    wait_tx_start();
    tick();
    do_reset();
    repeat (30) tick();
    send_frame(64'h1234_0005);
    serve_tx(1, 1'b0, 1'b0);
    repeat (3) tick();

    sel = 1'b1;                              // 32-bit instance
    W = 32;
    NB = 4;
    do_reset();
    repeat (2) tick();
    send_frame(64'hFFFF_FFFF_0000_0010);
    serve_tx(1, 1'b0, 1'b0);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
